// File: rtl/hctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// The tag width is tied to HC_AW; hazard_ctrl's AW parameter must equal it.
package hctrl_pkg;
    localparam int HC_AW = 5;
    localparam int HC_SW = 2;

    localparam logic [HC_SW-1:0] FWD_REG   = 2'd0;
    localparam logic [HC_SW-1:0] FWD_MEM   = 2'd1;
    localparam logic [HC_SW-1:0] FWD_WB    = 2'd2;
    localparam logic [HC_SW-1:0] FWD_WBDEC = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [HC_AW-1:0] add;
        logic             ld;
    } tag_t;

    localparam int   TAG_W    = $bits(tag_t);
    localparam tag_t TAG_NONE = '0;
endpackage

// File: rtl/hctrl_fwd_sel.sv
// Per-source forwarding priority encoder: youngest in-flight producer wins.
// HCTRL_R0_ZERO_EN: when defined, source address 0 never matches any tag.
module hctrl_fwd_sel
    import hctrl_pkg::*;
(
    input  logic [TAG_W-1:0] i_t_exe,
    input  logic [TAG_W-1:0] i_t_mem,
    input  logic [TAG_W-1:0] i_t_wb,
    input  logic [HC_AW-1:0] i_src_add,
    input  logic             i_src_vld,
    output logic [HC_SW-1:0] o_sel,
    output logic             o_ld_hit
);
    tag_t w_exe;
    tag_t w_mem;
    tag_t w_wb;
    logic w_src_ok;
    logic w_m_exe;
    logic w_m_mem;
    logic w_m_wb;
    logic w_prod_ld;

    assign w_exe = tag_t'(i_t_exe);
    assign w_mem = tag_t'(i_t_mem);
    assign w_wb  = tag_t'(i_t_wb);

`ifdef HCTRL_R0_ZERO_EN
    assign w_src_ok = i_src_vld && (i_src_add != '0);
`else
    assign w_src_ok = i_src_vld;
`endif

    assign w_m_exe = w_src_ok && w_exe.vld && (w_exe.add == i_src_add);
    assign w_m_mem = w_src_ok && w_mem.vld && (w_mem.add == i_src_add);
    assign w_m_wb  = w_src_ok && w_wb.vld  && (w_wb.add  == i_src_add);

    // w_prod_ld carries the load flag of whichever producer won the priority.
    always_comb begin
        o_sel     = FWD_REG;
        w_prod_ld = 1'b0;
        if (w_m_exe) begin
            o_sel     = FWD_MEM;
            w_prod_ld = w_exe.ld;
        end else if (w_m_mem) begin
            o_sel     = FWD_WB;
            w_prod_ld = w_mem.ld;
        end else if (w_m_wb) begin
            o_sel     = FWD_WBDEC;
            w_prod_ld = w_wb.ld;
        end
    end

    // Only a load still in EXE is too young to forward from.
    assign o_ld_hit = (o_sel == FWD_MEM) && w_prod_ld;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks EXE/MEM/WB destination tags, registers
// forwarding selects for EXE and inserts a one-cycle bubble on load-use. Option: HCTRL_R0_ZERO_EN.
module hazard_ctrl
    import hctrl_pkg::*;
#(
    parameter int AW = 5,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] dec_src1_add,
    input  logic [AW-1:0] dec_src2_add,
    input  logic [1:0]    dec_src_vld,
    input  logic [AW-1:0] dec_reg_wr_add,
    input  logic          dec_reg_wr_en,
    input  logic          dec_mem_rd,
    output logic [SW-1:0] mux1_hctr,
    output logic [SW-1:0] mux2_hctr,
    output logic          stall_pc,
    output logic          stall_dec,
    output logic          bubble_exe,
    output logic          dbg_state
);
    state_t        r_state;
    state_t        w_next_state;
    tag_t          r_t_exe;
    tag_t          r_t_mem;
    tag_t          r_t_wb;
    tag_t          w_dec_tag;
    logic [SW-1:0] r_mux1;
    logic [SW-1:0] r_mux2;
    logic          r_bubble;
    logic [SW-1:0] w_sel1;
    logic [SW-1:0] w_sel2;
    logic          w_ld_hit1;
    logic          w_ld_hit2;
    logic          w_stall;

    assign w_dec_tag = tag_t'({dec_reg_wr_en, dec_reg_wr_add, dec_mem_rd});

    hctrl_fwd_sel u_sel1 (
        .i_t_exe   (r_t_exe),
        .i_t_mem   (r_t_mem),
        .i_t_wb    (r_t_wb),
        .i_src_add (dec_src1_add),
        .i_src_vld (dec_src_vld[0]),
        .o_sel     (w_sel1),
        .o_ld_hit  (w_ld_hit1)
    );

    hctrl_fwd_sel u_sel2 (
        .i_t_exe   (r_t_exe),
        .i_t_mem   (r_t_mem),
        .i_t_wb    (r_t_wb),
        .i_src_add (dec_src2_add),
        .i_src_vld (dec_src_vld[1]),
        .o_sel     (w_sel2),
        .o_ld_hit  (w_ld_hit2)
    );

    // STALL never re-stalls: the bubble just placed in EXE cannot match.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            RUN: begin
                if (w_ld_hit1 || w_ld_hit2) begin
                    w_stall      = 1'b1;
                    w_next_state = STALL;
                end
            end
            STALL: begin
                w_next_state = RUN;
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_t_exe  <= TAG_NONE;
            r_t_mem  <= TAG_NONE;
            r_t_wb   <= TAG_NONE;
            r_mux1   <= FWD_REG;
            r_mux2   <= FWD_REG;
            r_bubble <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_t_mem <= r_t_exe;
            r_t_wb  <= r_t_mem;
            if (w_stall) begin
                r_t_exe  <= TAG_NONE;
                r_mux1   <= FWD_REG;
                r_mux2   <= FWD_REG;
                r_bubble <= 1'b1;
            end else begin
                r_t_exe  <= w_dec_tag;
                r_mux1   <= w_sel1;
                r_mux2   <= w_sel2;
                r_bubble <= 1'b0;
            end
        end
    end

    assign stall_pc   = w_stall && !rst;
    assign stall_dec  = w_stall && !rst;
    assign mux1_hctr  = r_mux1;
    assign mux2_hctr  = r_mux2;
    assign bubble_exe = r_bubble;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan steps then random traffic checked
// against an instruction-history model of the pipeline.
module tb_hazard_ctrl;
    typedef struct {
        logic [4:0] s1;
        logic [4:0] s2;
        logic [1:0] sv;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ins_t;

    logic       clk;
    logic       rst;
    logic [4:0] dec_src1_add;
    logic [4:0] dec_src2_add;
    logic [1:0] dec_src_vld;
    logic [4:0] dec_reg_wr_add;
    logic       dec_reg_wr_en;
    logic       dec_mem_rd;
    logic [1:0] mux1_hctr;
    logic [1:0] mux2_hctr;
    logic       stall_pc;
    logic       stall_dec;
    logic       bubble_exe;
    logic       dbg_state;

    int checks   = 0;
    int failures = 0;

    // Model: the last three instructions to enter EXE, index 0 = now in EXE.
    logic       m_vld[3];
    logic [4:0] m_add[3];
    logic       m_ld[3];
    logic [4:0] exp_q[$];

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .dec_src1_add   (dec_src1_add),
        .dec_src2_add   (dec_src2_add),
        .dec_src_vld    (dec_src_vld),
        .dec_reg_wr_add (dec_reg_wr_add),
        .dec_reg_wr_en  (dec_reg_wr_en),
        .dec_mem_rd     (dec_mem_rd),
        .mux1_hctr      (mux1_hctr),
        .mux2_hctr      (mux2_hctr),
        .stall_pc       (stall_pc),
        .stall_dec      (stall_dec),
        .bubble_exe     (bubble_exe),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t op(input int rd, input int s1, input int s2, input logic [1:0] sv);
        ins_t r;
        r.rd = 5'(rd); r.s1 = 5'(s1); r.s2 = 5'(s2); r.sv = sv;
        r.we = 1'b1; r.ld = 1'b0;
        return r;
    endfunction

    function automatic ins_t ldi(input int rd);
        ins_t r;
        r = op(rd, 1, 0, 2'b01);
        r.ld = 1'b1;
        return r;
    endfunction

    function automatic bit hit(input int i, input logic [4:0] a);
`ifdef HCTRL_R0_ZERO_EN
        if (a == 5'd0) return 1'b0;
`endif
        return m_vld[i] && (m_add[i] == a);
    endfunction

    function automatic logic [1:0] sel_for(input logic [4:0] a, input logic v);
        if (!v) return 2'd0;
        for (int i = 0; i < 3; i++)
            if (hit(i, a)) return 2'(i + 1);
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_vld[i] = 1'b0; m_add[i] = '0; m_ld[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_push(input logic v, input logic [4:0] a, input logic l);
        for (int i = 2; i > 0; i--) begin
            m_vld[i] = m_vld[i-1]; m_add[i] = m_add[i-1]; m_ld[i] = m_ld[i-1];
        end
        m_vld[0] = v; m_add[0] = a; m_ld[0] = l;
    endtask

    task automatic drive(input ins_t d);
        dec_src1_add   = d.s1;
        dec_src2_add   = d.s2;
        dec_src_vld    = d.sv;
        dec_reg_wr_add = d.rd;
        dec_reg_wr_en  = d.we;
        dec_mem_rd     = d.ld;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(op(0, 0, 0, 2'b00));
        dec_reg_wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mux1", 8'(mux1_hctr), 8'd0);
        chk("rst_mux2", 8'(mux2_hctr), 8'd0);
        chk("rst_bubble", 8'(bubble_exe), 8'd0);
        chk("rst_stall_pc", 8'(stall_pc), 8'd0);
        chk("rst_state", 8'(dbg_state), 8'd0);
        rst = 1'b0;
        model_clear();
    endtask

    // One clock with d held in DEC; reports whether the DUT should stall.
    task automatic run_cycle(input ins_t d, output bit stalled);
        logic [1:0] e1, e2;
        logic [4:0] e;
        bit hz;
        drive(d);
        #1;
        e1 = sel_for(d.s1, d.sv[0]);
        e2 = sel_for(d.s2, d.sv[1]);
        hz = m_ld[0] && ((d.sv[0] && hit(0, d.s1)) || (d.sv[1] && hit(0, d.s2)));
        chk("stall_pc", 8'(stall_pc), 8'(hz));
        chk("stall_dec", 8'(stall_dec), 8'(hz));
        if (hz) begin
            exp_q.push_back({1'b1, 2'd0, 2'd0});
            model_push(1'b0, '0, 1'b0);
        end else begin
            exp_q.push_back({1'b0, e1, e2});
            model_push(d.we, d.rd, d.ld);
        end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("bubble_exe", 8'(bubble_exe), 8'(e[4]));
        chk("state", 8'(dbg_state), 8'(e[4]));
        chk("mux1", 8'(mux1_hctr), 8'(e[3:2]));
        chk("mux2", 8'(mux2_hctr), 8'(e[1:0]));
        stalled = hz;
    endtask

    task automatic issue(input ins_t d, output int nst);
        bit s;
        nst = 0;
        run_cycle(d, s);
        while (s && nst < 3) begin
            nst++;
            run_cycle(d, s);
        end
        chk("issue_done", 8'(s), 8'd0);
    endtask

    initial begin
        int n;
        bit s;
        ins_t r;
        model_clear();
        do_reset();

        // back-to-back dependency forwards from MEM
        issue(op(3, 1, 2, 2'b11), n);
        issue(op(4, 3, 1, 2'b11), n);
        chk("b2b_mux1", 8'(mux1_hctr), 8'd1);
        chk("b2b_nostall", 8'(n), 8'd0);

        // distance 2, 3, 4 on src2
        issue(op(5, 1, 2, 2'b11), n);
        issue(op(20, 21, 22, 2'b11), n);
        issue(op(12, 13, 5, 2'b10), n);
        chk("dist2_mux2", 8'(mux2_hctr), 8'd2);
        issue(op(5, 1, 2, 2'b11), n);
        issue(op(20, 21, 22, 2'b11), n);
        issue(op(23, 21, 22, 2'b11), n);
        issue(op(12, 13, 5, 2'b10), n);
        chk("dist3_mux2", 8'(mux2_hctr), 8'd3);
        issue(op(5, 1, 2, 2'b11), n);
        issue(op(20, 21, 22, 2'b11), n);
        issue(op(23, 21, 22, 2'b11), n);
        issue(op(24, 21, 22, 2'b11), n);
        issue(op(12, 13, 5, 2'b10), n);
        chk("dist4_mux2", 8'(mux2_hctr), 8'd0);

        // load-use: one stall, bubble in EXE, then both from WB
        issue(ldi(7), n);
        run_cycle(op(8, 7, 7, 2'b11), s);
        chk("lu_stall", 8'(s), 8'd1);
        chk("lu_bubble", 8'(bubble_exe), 8'd1);
        chk("lu_bub_mux1", 8'(mux1_hctr), 8'd0);
        run_cycle(op(8, 7, 7, 2'b11), s);
        chk("lu_once", 8'(s), 8'd0);
        chk("lu_mux1", 8'(mux1_hctr), 8'd2);
        chk("lu_mux2", 8'(mux2_hctr), 8'd2);
        chk("lu_nobubble", 8'(bubble_exe), 8'd0);

        // youngest producer wins
        issue(op(2, 1, 1, 2'b11), n);
        issue(op(2, 1, 1, 2'b11), n);
        issue(op(9, 2, 1, 2'b01), n);
        chk("young_mux1", 8'(mux1_hctr), 8'd1);

        // r0 load-use
        issue(ldi(0), n);
        issue(op(14, 0, 0, 2'b11), n);
`ifdef HCTRL_R0_ZERO_EN
        chk("r0_nst", 8'(n), 8'd0);
        chk("r0_mux1", 8'(mux1_hctr), 8'd0);
`else
        chk("r0_nst", 8'(n), 8'd1);
        chk("r0_mux1", 8'(mux1_hctr), 8'd2);
`endif

        // reset while in STALL
        issue(ldi(7), n);
        run_cycle(op(8, 7, 7, 2'b11), s);
        chk("rs_stall", 8'(s), 8'd1);
        rst = 1'b1;
        #1;
        chk("rs_stall_pc", 8'(stall_pc), 8'd0);
        chk("rs_stall_dec", 8'(stall_dec), 8'd0);
        @(posedge clk); #1;
        chk("rs_state", 8'(dbg_state), 8'd0);
        chk("rs_bubble", 8'(bubble_exe), 8'd0);
        chk("rs_mux1", 8'(mux1_hctr), 8'd0);
        chk("rs_mux2", 8'(mux2_hctr), 8'd0);
        rst = 1'b0;
        model_clear();
        issue(op(8, 7, 7, 2'b11), n);
        chk("rs_clean", 8'(n), 8'd0);
        chk("rs_tags_cleared", 8'(mux1_hctr), 8'd0);
        issue(op(10, 1, 8, 2'b10), n);
        chk("rs_fwd_mux2", 8'(mux2_hctr), 8'd1);

        // random traffic over a narrow register range
        for (int i = 0; i < 400; i++) begin
            r.s1 = 5'($urandom_range(0, 7));
            r.s2 = 5'($urandom_range(0, 7));
            r.sv = 2'($urandom_range(0, 3));
            r.rd = 5'($urandom_range(0, 7));
            r.we = ($urandom_range(0, 9) < 8);
            r.ld = ($urandom_range(0, 9) < 3);
            issue(r, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
